// File: rtl/adpll_lock_detect.sv
// Lock detector for adpll_top. It samples the phase-error magnitude once per reference
// period and applies consecutive-count hysteresis to declare or drop lock. A reference
// timeout flags a lost clk_ref and forces the detector back to unlocked.
// Optional feature: define ADPLL_LOCK_HIST_EN to enable the saturating slip_count history.
module adpll_lock_detect #(
  parameter int unsigned ERR_W      = 5,
  parameter int unsigned LOCK_TOL   = 2,
  parameter int unsigned LOCK_CNT   = 16,
  parameter int unsigned UNLOCK_CNT = 4,
  parameter int unsigned TIMEOUT    = 64,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             clk_ref,
  input  logic [ERR_W-1:0] dout,
  input  logic             sign,
  output logic             ref_tick,
  output logic             locked,
  output logic [1:0]       lock_state,
  output logic             lock_pulse,
  output logic             unlock_pulse,
  output logic             ref_lost,
  output logic [7:0]       slip_count
);

  typedef enum logic [1:0] {
    StUnlocked = 2'd0,
    StAcquire  = 2'd1,
    StLocked   = 2'd2,
    StSlip     = 2'd3
  } state_e;

  localparam logic [ERR_W-1:0] LockTolC    = ERR_W'(LOCK_TOL);
  localparam logic [CNT_W-1:0] LockCntC    = CNT_W'(LOCK_CNT);
  localparam logic [CNT_W-1:0] UnlockCntC  = CNT_W'(UNLOCK_CNT);
  localparam logic [CNT_W-1:0] TimeoutC    = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] OneC        = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] good_cnt_q, good_cnt_d;
  logic [CNT_W-1:0] bad_cnt_q, bad_cnt_d;
  logic [CNT_W-1:0] to_cnt_q, to_cnt_d;
  logic             lock_pulse_q, lock_pulse_d;
  logic             unlock_pulse_q, unlock_pulse_d;
  logic             ref_lost_q, ref_lost_d;
  logic [2:0]       ref_sync_q;
  logic             in_tol;
  logic             to_hit;
  logic [CNT_W-1:0] good_inc;
  logic [CNT_W-1:0] bad_inc;

  // The sign does not affect qualification; only the magnitude matters.
  logic unused_sign;
  assign unused_sign = sign;

  // Two-flop synchroniser for clk_ref plus one delay flop for edge detection.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      ref_sync_q <= 3'b000;
    end else begin
      ref_sync_q <= {ref_sync_q[1:0], clk_ref};
    end
  end

  assign ref_tick = ref_sync_q[1] & ~ref_sync_q[2];
  assign in_tol   = (dout <= LockTolC);
  assign good_inc = good_cnt_q + OneC;
  assign bad_inc  = bad_cnt_q + OneC;
  // Fires only on the edge where the saturating counter first reaches TIMEOUT.
  assign to_hit   = ~ref_tick && (to_cnt_q != TimeoutC) && ((to_cnt_q + OneC) == TimeoutC);

  // State, counter and registered-pulse update.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state_q        <= StUnlocked;
      good_cnt_q     <= '0;
      bad_cnt_q      <= '0;
      to_cnt_q       <= '0;
      lock_pulse_q   <= 1'b0;
      unlock_pulse_q <= 1'b0;
      ref_lost_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      good_cnt_q     <= good_cnt_d;
      bad_cnt_q      <= bad_cnt_d;
      to_cnt_q       <= to_cnt_d;
      lock_pulse_q   <= lock_pulse_d;
      unlock_pulse_q <= unlock_pulse_d;
      ref_lost_q     <= ref_lost_d;
    end
  end

  // Next-state logic: samples are taken only on ref_tick; otherwise only the timeout acts.
  always_comb begin
    state_d        = state_q;
    good_cnt_d     = good_cnt_q;
    bad_cnt_d      = bad_cnt_q;
    lock_pulse_d   = 1'b0;
    unlock_pulse_d = 1'b0;
    ref_lost_d     = ref_lost_q;
    to_cnt_d       = (to_cnt_q != TimeoutC) ? to_cnt_q + OneC : to_cnt_q;
    if (ref_tick) begin
      to_cnt_d   = '0;
      ref_lost_d = 1'b0;
      unique case (state_q)
        StUnlocked: begin
          if (in_tol) begin
            state_d    = StAcquire;
            good_cnt_d = OneC;
          end
        end
        StAcquire: begin
          if (!in_tol) begin
            state_d    = StUnlocked;
            good_cnt_d = '0;
          end else if (good_inc == LockCntC) begin
            state_d      = StLocked;
            good_cnt_d   = '0;
            lock_pulse_d = 1'b1;
          end else begin
            good_cnt_d = good_inc;
          end
        end
        StLocked: begin
          if (!in_tol) begin
            if (OneC == UnlockCntC) begin
              state_d        = StUnlocked;
              bad_cnt_d      = '0;
              unlock_pulse_d = 1'b1;
            end else begin
              state_d   = StSlip;
              bad_cnt_d = OneC;
            end
          end
        end
        StSlip: begin
          if (in_tol) begin
            // Lock was never lost, so no pulse here.
            state_d   = StLocked;
            bad_cnt_d = '0;
          end else if (bad_inc == UnlockCntC) begin
            state_d        = StUnlocked;
            bad_cnt_d      = '0;
            unlock_pulse_d = 1'b1;
          end else begin
            bad_cnt_d = bad_inc;
          end
        end
        default: state_d = StUnlocked;
      endcase
    end else if (to_hit) begin
      ref_lost_d     = 1'b1;
      state_d        = StUnlocked;
      good_cnt_d     = '0;
      bad_cnt_d      = '0;
      unlock_pulse_d = (state_q == StLocked) || (state_q == StSlip);
    end
  end

  // Outputs decoded from the state register and pulse flops.
  always_comb begin
    lock_state   = state_q;
    locked       = (state_q == StLocked) || (state_q == StSlip);
    lock_pulse   = lock_pulse_q;
    unlock_pulse = unlock_pulse_q;
    ref_lost     = ref_lost_q;
  end

`ifdef ADPLL_LOCK_HIST_EN
  logic [7:0] slip_cnt_q;

  // Saturating count of lock losses; clr never raises a pulse, so it leaves this untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      slip_cnt_q <= 8'd0;
    end else if (!clr && unlock_pulse_d && (slip_cnt_q != 8'hff)) begin
      slip_cnt_q <= slip_cnt_q + 8'd1;
    end
  end

  assign slip_count = slip_cnt_q;
`else
  assign slip_count = 8'd0;
`endif

endmodule
